// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, parity selectors and frame-length constants for the TX and RX paths
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int FRAME_LEN_NOPAR = DATA_WIDTH_DEF + 2;
  localparam int FRAME_LEN_PAR   = DATA_WIDTH_DEF + 3;
  function automatic int frame_len(input logic par_en);
    return par_en ? FRAME_LEN_PAR : FRAME_LEN_NOPAR;
  endfunction
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational frame parity, even for par_typ=PAR_EVEN and odd for PAR_ODD
module uart_parity_calc import uart_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);
  assign par = ^data ^ par_typ;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serializer with optional parity; define UART_TX_BUF_EN for a one-entry holding buffer
module uart_tx import uart_pkg::*; #(
  parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  BIT_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);
  localparam int CW = $clog2(DATA_WIDTH + 3);
  logic [2:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shadow, hold_d;
  logic pe, pt, pending, pending_n, busy_n, tx_n, par, sh_bit;
  logic stop_exit, to_shadow, move, hold_pe, hold_pt;
  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (.data(shadow), .par_typ(pt), .par(par));
  assign stop_exit = state == ST_STOP && BIT_TICK;
  assign sh_bit = 1'(shadow >> cnt_n);
`ifdef UART_TX_BUF_EN
  logic hold_full, acc;
  assign acc = DATA_VALID && !hold_full;
  // a request goes straight to the shifter when it is free or being freed this tick
  assign to_shadow = acc && (!pending || stop_exit);
  assign move = stop_exit && hold_full;
  assign busy_n = pending_n && ((acc && !to_shadow) || (hold_full && !move));
  always_ff @(posedge clk)
    if (RST) begin
      hold_full <= 1'b0;
      hold_d <= '0;
      hold_pe <= 1'b0;
      hold_pt <= 1'b0;
    end else begin
      hold_full <= (acc && !to_shadow) || (hold_full && !move);
      if (acc && !to_shadow) begin
        hold_d <= P_DATA;
        hold_pe <= PAR_EN;
        hold_pt <= PAR_TYP;
      end
    end
`else
  assign to_shadow = DATA_VALID && !Busy;
  assign move = 1'b0;
  assign hold_d = '0;
  assign hold_pe = 1'b0;
  assign hold_pt = 1'b0;
  assign busy_n = pending_n;
`endif
  assign pending_n = (to_shadow || move) ? 1'b1 : stop_exit ? 1'b0 : pending;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (BIT_TICK)
      case (state)
        ST_IDLE: state_n = pending ? ST_START : ST_IDLE;
        ST_START: begin
          state_n = ST_DATA;
          cnt_n = '0;
        end
        ST_DATA: begin
          state_n = cnt == CW'(DATA_WIDTH - 1) ? (pe ? ST_PARITY : ST_STOP) : ST_DATA;
          cnt_n = cnt + CW'(1);
        end
        ST_PARITY: state_n = ST_STOP;
        default: state_n = move ? ST_START : ST_IDLE;
      endcase
  end
  // the line is registered from the next state so each bit appears right after its tick
  assign tx_n = state_n == ST_START ? ~IDLE_LEVEL : state_n == ST_DATA ? sh_bit :
                state_n == ST_PARITY ? par : IDLE_LEVEL;
  always_ff @(posedge clk)
    if (RST) begin
      state <= ST_IDLE;
      cnt <= '0;
      shadow <= '0;
      pe <= 1'b0;
      pt <= 1'b0;
      pending <= 1'b0;
      TX_OUT <= IDLE_LEVEL;
      Busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pending <= pending_n;
      TX_OUT <= tx_n;
      Busy <= busy_n;
      if (to_shadow) begin
        shadow <= P_DATA;
        pe <= PAR_EN;
        pt <= PAR_TYP;
      end else if (move) begin
        shadow <= hold_d;
        pe <= hold_pe;
        pt <= hold_pt;
      end
    end
endmodule
